spi_xfer_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one SPI transfer engine between up to N_REQ requesters (CPU-side Avalon bridge, DMA, housekeeping poller). Accepts one 32-bit full-duplex transfer request at a time, launches it on the SPI core with a single-cycle go pulse and waits for the core's completion edge. Returns the received word and a per-requester done pulse. A watchdog aborts transfers the core never completes.

---
 rtl/spi_xfer_arbiter.sv | 158 +++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
//   Shares one SPI transfer engine between up to N_REQ requesters. A
//   round-robin pick selects one pending request. Its word goes to the core
//   with a one-cycle go pulse. The arbiter then waits for the core's
//   completion edge and returns the received word with a one-cycle done
//   pulse to the owner. A watchdog aborts a transfer the core never
//   finishes and flags it through err.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   req                 per-requester request level, held until its done
//   req_wdata           packed request words, requester i at [i*DW +: DW]
//   grant               one-hot owner, high from LAUNCH through DONE
//   done                one-cycle one-hot completion pulse
//   rdata, err          received word / timeout flag, valid with done
//   busy                high whenever the sequencer is not idle
//   go_transfer         one-cycle start pulse to the SPI core
//   data_write_to_spi   word for the core, stable from launch to next launch
//   data_pack_ready     core completion level (rising edge = complete)
//   data_read_from_spi  word from the core, valid on that rising edge

module spi_xfer_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic [DW-1:0]       rdata,
  output logic                err,
  output logic                busy,
  output logic                go_transfer,
  output logic [DW-1:0]       data_write_to_spi,
  input  logic                data_pack_ready,
  input  logic [DW-1:0]       data_read_from_spi
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   scan_idx;
  logic [PW:0]     scan_sum;
  logic            pick_valid;
  logic [DW-1:0]   words [N_REQ];
  logic [CW-1:0]   wait_cnt;
  logic            dpr_q;
  logic            completion;
  logic            expired;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_wdata[g*DW +: DW];
  end

  // The scan starts at ptr and wraps modulo N_REQ. N_REQ need not be a power
  // of two, so the wrap is a single conditional subtract on a one-bit-wider
  // sum rather than natural overflow.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      scan_sum = {1'b0, ptr} + (PW+1)'(off);
      if (scan_sum >= (PW+1)'(N_REQ))
        scan_sum = scan_sum - (PW+1)'(N_REQ);
      scan_idx = scan_sum[PW-1:0];
      if (!pick_valid && req[scan_idx]) begin
        pick_valid = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  // A completion edge counts only while waiting. An edge that arrived during
  // launch has already been absorbed into dpr_q by the first wait cycle.
  assign completion = data_pack_ready & ~dpr_q;
  assign expired    = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) dpr_q <= 1'b0;
    else       dpr_q <= data_pack_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    go_transfer = 1'b0;
    done        = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE:    if (pick_valid) state_next = LAUNCH;
      LAUNCH: begin
        go_transfer = 1'b1;
        state_next  = WAIT;
      end
      WAIT:    if (completion || expired) state_next = DONE;
      DONE: begin
        done       = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion takes priority over the watchdog when both occur in the same
  // cycle. A successful transfer is never reported as a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant             <= '0;
      winner            <= '0;
      ptr               <= '0;
      data_write_to_spi <= '0;
      rdata             <= '0;
      err               <= 1'b0;
      wait_cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          grant             <= N_REQ'(1) << pick;
          winner            <= pick;
          data_write_to_spi <= words[pick];
        end
        LAUNCH: wait_cnt <= '0;
        WAIT: begin
          if (completion) begin
            rdata <= data_read_from_spi;
            err   <= 1'b0;
          end else if (expired) begin
            rdata <= '0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          grant <= '0;
          ptr   <= (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
module tb_spi_xfer_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant, done;
  logic [DW-1:0]   rdata, data_write_to_spi, data_read_from_spi;
  logic            err, busy, go_transfer, data_pack_ready;

  int checks   = 0;
  int failures = 0;

  spi_xfer_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .go_transfer(go_transfer), .data_write_to_spi(data_write_to_spi),
    .data_pack_ready(data_pack_ready), .data_read_from_spi(data_read_from_spi)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; data_pack_ready = 1'b0;
    data_read_from_spi = '0; req_wdata = '0;
    step(); step();
    checks++; if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
    checks++; if ({busy, go_transfer, err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, go_transfer, err}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if (data_write_to_spi !== 32'h0) begin failures++; $display("[TB] FAIL reset_dwrite: got %h expected 00000000", data_write_to_spi); end
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    req_wdata = {32'h33333333, 32'h22222222, 32'hA5A5A5A5, 32'h11111111};
    req = 4'b0010;
    step();
    checks++; if (go_transfer !== 1'b1) begin failures++; $display("[TB] FAIL single_go: got %b expected 1", go_transfer); end
    checks++; if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL single_grant: got %b expected 0010", grant); end
    checks++; if (data_write_to_spi !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL single_dwrite: got %h expected a5a5a5a5", data_write_to_spi); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    req_wdata[DW +: DW] = 32'h0;
    step();
    for (int i = 0; i < 9; i++) begin
      checks++; if ({go_transfer, done} !== 5'b0) begin failures++; $display("[TB] FAIL single_wait_idle_outputs: got %b expected 00000", {go_transfer, done}); end
      step();
    end
    checks++; if (data_write_to_spi !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL single_dwrite_stable: got %h expected a5a5a5a5", data_write_to_spi); end
    data_pack_ready = 1'b1; data_read_from_spi = 32'h12345678;
    step();
    checks++; if (done !== 4'b0010) begin failures++; $display("[TB] FAIL single_done: got %b expected 0010", done); end
    checks++; if (rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL single_rdata: got %h expected 12345678", rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL single_err: got %b expected 0", err); end
    req = '0; data_pack_ready = 1'b0;
    step();
    checks++; if ({done, busy, grant} !== 9'b0) begin failures++; $display("[TB] FAIL single_after_done: got %b expected 000000000", {done, busy, grant}); end
    checks++; if (rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL single_rdata_held: got %h expected 12345678", rdata); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] w [4] = '{32'hC0C0_0000, 32'hC1C1_1111, 32'hC2C2_2222, 32'hC3C3_3333};
    logic [N-1:0] exp_g;
    int gos;
    reset = 1'b1; step(); reset = 1'b0;
    req_wdata = {w[3], w[2], w[1], w[0]};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << order[t];
      gos = 0;
      step();
      gos += int'(go_transfer);
      checks++; if (grant !== exp_g) begin failures++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", t, grant, exp_g); end
      checks++; if (data_write_to_spi !== w[order[t]]) begin failures++; $display("[TB] FAIL rr_dwrite[%0d]: got %h expected %h", t, data_write_to_spi, w[order[t]]); end
      step();
      gos += int'(go_transfer);
      data_pack_ready = 1'b1; data_read_from_spi = 32'h1000 + 32'(t);
      step();
      gos += int'(go_transfer);
      checks++; if (done !== exp_g) begin failures++; $display("[TB] FAIL rr_done[%0d]: got %b expected %b", t, done, exp_g); end
      checks++; if (rdata !== 32'h1000 + 32'(t)) begin failures++; $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", t, rdata, 32'h1000 + 32'(t)); end
      data_pack_ready = 1'b0;
      step();
      gos += int'(go_transfer);
      checks++; if (gos != 1) begin failures++; $display("[TB] FAIL rr_go_count[%0d]: got %0d expected 1", t, gos); end
    end
    req = '0;
    step();
  endtask

  task automatic test_timeout();
    req = 4'b0100; data_read_from_spi = 32'hFFFF_FFFF; data_pack_ready = 1'b0;
    step();
    checks++; if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL to_grant: got %b expected 0100", grant); end
    for (int i = 0; i < TO; i++) step();
    checks++; if ({done, busy} !== 5'b00001) begin failures++; $display("[TB] FAIL to_early: got %b expected 00001", {done, busy}); end
    step();
    checks++; if (done !== 4'b0100) begin failures++; $display("[TB] FAIL to_done: got %b expected 0100", done); end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL to_err: got %b expected 1", err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL to_rdata: got %h expected 00000000", rdata); end
    req = '0;
    step();
    checks++; if ({busy, done} !== 5'b0) begin failures++; $display("[TB] FAIL to_after: got %b expected 00000", {busy, done}); end
  endtask

  task automatic test_simultaneous();
    req = 4'b0010;
    step();
    for (int i = 0; i < TO; i++) step();
    checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL sim_early: got %b expected 0000", done); end
    data_pack_ready = 1'b1; data_read_from_spi = 32'hCAFEF00D;
    step();
    checks++; if (done !== 4'b0010) begin failures++; $display("[TB] FAIL sim_done: got %b expected 0010", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL sim_err: got %b expected 0", err); end
    checks++; if (rdata !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL sim_rdata: got %h expected cafef00d", rdata); end
    req = '0; data_pack_ready = 1'b0;
    step();
  endtask

  task automatic test_pending_edge();
    req = 4'b0001;
    step();
    checks++; if (go_transfer !== 1'b1) begin failures++; $display("[TB] FAIL pend_go: got %b expected 1", go_transfer); end
    data_pack_ready = 1'b1; data_read_from_spi = 32'hDEADBEEF;
    for (int i = 0; i < TO; i++) step();
    checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL pend_early: got %b expected 0000", done); end
    step();
    checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL pend_done: got %b expected 0001", done); end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL pend_err: got %b expected 1", err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL pend_rdata: got %h expected 00000000", rdata); end
    req = '0; data_pack_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    step(); step(); step();
    reset = 1'b1; req = '0;
    step();
    checks++; if ({grant, done, busy, go_transfer, err} !== 11'b0) begin failures++; $display("[TB] FAIL rst_mid_outputs: got %b expected 00000000000", {grant, done, busy, go_transfer, err}); end
    reset = 1'b0; data_pack_ready = 1'b1; data_read_from_spi = 32'hBEEF;
    step();
    checks++; if ({done, busy} !== 5'b0) begin failures++; $display("[TB] FAIL rst_mid_late_edge: got %b expected 00000", {done, busy}); end
    data_pack_ready = 1'b0; req = 4'b1001;
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL rst_mid_ptr_grant: got %b expected 0001", grant); end
    step();
    data_pack_ready = 1'b1; data_read_from_spi = 32'h33;
    step();
    checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL rst_mid_done: got %b expected 0001", done); end
    checks++; if (rdata !== 32'h33) begin failures++; $display("[TB] FAIL rst_mid_rdata: got %h expected 00000033", rdata); end
    req = '0; data_pack_ready = 1'b0;
    step();
  endtask

  task automatic test_req_drop();
    req = 4'b0001;
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL drop_grant: got %b expected 0001", grant); end
    step(); step();
    req = '0;
    step(); step();
    data_pack_ready = 1'b1; data_read_from_spi = 32'h77;
    step();
    checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL drop_done: got %b expected 0001", done); end
    checks++; if (rdata !== 32'h77) begin failures++; $display("[TB] FAIL drop_rdata: got %h expected 00000077", rdata); end
    data_pack_ready = 1'b0;
    step();
    checks++; if ({grant, busy} !== 5'b0) begin failures++; $display("[TB] FAIL drop_after: got %b expected 00000", {grant, busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_pending_edge();
    test_reset_mid();
    test_req_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
